// File: rtl/r4_butter_ctrl.sv
// Frame sequencer for the radix-4 butterfly: gathers four complex samples,
// steps the butterfly through bins k = 0..3 and streams the results out.
module r4_butter_ctrl #(
  parameter int W        = 4,
  parameter int BFLY_LAT = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  input  logic         inv,
  output logic [W-1:0] xr0,
  output logic [W-1:0] xr1,
  output logic [W-1:0] xr2,
  output logic [W-1:0] xr3,
  output logic [W-1:0] xi0,
  output logic [W-1:0] xi1,
  output logic [W-1:0] xi2,
  output logic [W-1:0] xi3,
  output logic         c1,
  output logic         c2,
  output logic         c3,
  input  logic [W-1:0] Xro,
  input  logic [W-1:0] Xio,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic [1:0]   out_k,
  output logic         out_last,
  output logic         busy
);

  typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_WAIT, S_OUT} state_t;

  localparam logic [2:0] LAT = 3'(BFLY_LAT);

  state_t       state, state_nxt;
  logic [1:0]   n;
  logic [1:0]   k;
  logic [2:0]   cnt;
  logic [W-1:0] xr_q [4];
  logic [W-1:0] xi_q [4];

  assign xr0 = xr_q[0];
  assign xr1 = xr_q[1];
  assign xr2 = xr_q[2];
  assign xr3 = xr_q[3];
  assign xi0 = xi_q[0];
  assign xi1 = xi_q[1];
  assign xi2 = xi_q[2];
  assign xi3 = xi_q[3];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_LOAD;
    else      state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_LOAD:  if (in_valid && in_ready && n == 2'd3) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (cnt == 3'd1) state_nxt = S_OUT;
      S_OUT:   if (out_ready) state_nxt = (k == 2'd3) ? S_LOAD : S_ISSUE;
      default: state_nxt = S_LOAD;
    endcase
  end

  // Handshake outputs are pure decodes of the state register, so out_ready
  // never reaches in_ready combinationally.
  always_comb begin
    in_ready  = (state == S_LOAD);
    busy      = (state != S_LOAD);
    out_valid = (state == S_OUT);
  end

  // NOTE: the sample slots drive the butterfly directly, so they are reset like any other output register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      n        <= '0;
      k        <= '0;
      cnt      <= '0;
      c1       <= 1'b0;
      c2       <= 1'b0;
      c3       <= 1'b0;
      out_re   <= '0;
      out_im   <= '0;
      out_k    <= '0;
      out_last <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        xr_q[i] <= '0;
        xi_q[i] <= '0;
      end
    end else begin
      unique case (state)
        S_LOAD: begin
          if (in_valid && in_ready) begin
            xr_q[n] <= in_re;
            xi_q[n] <= in_im;
            if (n == 2'd0) c3 <= inv;
            n <= n + 2'd1;
            if (n == 2'd3) begin
              k        <= '0;
              {c2, c1} <= 2'd0;
            end
          end
        end
        S_ISSUE: cnt <= LAT;
        S_WAIT: begin
          if (cnt == 3'd1) begin
            out_re   <= Xro;
            out_im   <= Xio;
            out_k    <= k;
            out_last <= (k == 2'd3);
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            if (k == 2'd3) begin
              k <= '0;
              n <= '0;
            end else begin
              k        <= k + 2'd1;
              {c2, c1} <= k + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_r4_butter_ctrl.sv
// Self-checking bench for r4_butter_ctrl: a frame-level model checks the
// BFLY_LAT=1 instance every cycle; a BFLY_LAT=3 instance checks latency.
module tb_r4_butter_ctrl;

  localparam int LAT1 = 1;

  typedef struct {
    logic [1:0] k;
    logic [3:0] re;
    logic [3:0] im;
    logic       last;
  } res_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // BFLY_LAT = 1 instance
  logic       in_valid, in_ready, inv;
  logic [3:0] in_re, in_im;
  logic [3:0] xr0, xr1, xr2, xr3, xi0, xi1, xi2, xi3;
  logic       c1, c2, c3;
  logic [3:0] xro, xio;
  logic       out_valid, out_ready, out_last, busy;
  logic [3:0] out_re, out_im;
  logic [1:0] out_k;

  // BFLY_LAT = 3 instance
  logic       d3_in_valid, d3_in_ready, d3_inv;
  logic [3:0] d3_in_re, d3_in_im;
  logic [3:0] d3_xr0, d3_xr1, d3_xr2, d3_xr3, d3_xi0, d3_xi1, d3_xi2, d3_xi3;
  logic       d3_c1, d3_c2, d3_c3;
  logic [3:0] d3_xro, d3_xio;
  logic       d3_out_valid, d3_out_ready, d3_out_last, d3_busy;
  logic [3:0] d3_out_re, d3_out_im;
  logic [1:0] d3_out_k;

  r4_butter_ctrl #(.W(4), .BFLY_LAT(1)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im), .inv(inv),
    .xr0(xr0), .xr1(xr1), .xr2(xr2), .xr3(xr3),
    .xi0(xi0), .xi1(xi1), .xi2(xi2), .xi3(xi3),
    .c1(c1), .c2(c2), .c3(c3), .Xro(xro), .Xio(xio),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_k(out_k), .out_last(out_last), .busy(busy)
  );

  r4_butter_ctrl #(.W(4), .BFLY_LAT(3)) dut3 (
    .CLK(CLK), .RST(RST),
    .in_valid(d3_in_valid), .in_ready(d3_in_ready), .in_re(d3_in_re), .in_im(d3_in_im), .inv(d3_inv),
    .xr0(d3_xr0), .xr1(d3_xr1), .xr2(d3_xr2), .xr3(d3_xr3),
    .xi0(d3_xi0), .xi1(d3_xi1), .xi2(d3_xi2), .xi3(d3_xi3),
    .c1(d3_c1), .c2(d3_c2), .c3(d3_c3), .Xro(d3_xro), .Xio(d3_xio),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready), .out_re(d3_out_re), .out_im(d3_out_im),
    .out_k(d3_out_k), .out_last(d3_out_last), .busy(d3_busy)
  );

  // Butterfly stand-in: bin k returns sample k offset by k+5 (real) and
  // sample k xored with {inv,0,k} (imaginary).
  function automatic logic [3:0] pick(input logic [3:0] a0, input logic [3:0] a1,
                                      input logic [3:0] a2, input logic [3:0] a3,
                                      input logic [1:0] k);
    case (k)
      2'd0:    return a0;
      2'd1:    return a1;
      2'd2:    return a2;
      default: return a3;
    endcase
  endfunction

  function automatic logic [3:0] bf_re(input logic [3:0] a0, input logic [3:0] a1,
                                       input logic [3:0] a2, input logic [3:0] a3,
                                       input logic [1:0] k);
    return pick(a0, a1, a2, a3, k) + {2'b00, k} + 4'd5;
  endfunction

  function automatic logic [3:0] bf_im(input logic [3:0] a0, input logic [3:0] a1,
                                       input logic [3:0] a2, input logic [3:0] a3,
                                       input logic [1:0] k, input logic c);
    return pick(a0, a1, a2, a3, k) ^ {c, 1'b0, k};
  endfunction

  always @(posedge CLK) begin
    xro <= bf_re(xr0, xr1, xr2, xr3, {c2, c1});
    xio <= bf_im(xi0, xi1, xi2, xi3, {c2, c1}, c3);
  end

  logic [3:0] d3_pr [3];
  logic [3:0] d3_pi [3];
  always @(posedge CLK) begin
    d3_pr[0] <= bf_re(d3_xr0, d3_xr1, d3_xr2, d3_xr3, {d3_c2, d3_c1});
    d3_pi[0] <= bf_im(d3_xi0, d3_xi1, d3_xi2, d3_xi3, {d3_c2, d3_c1}, d3_c3);
    d3_pr[1] <= d3_pr[0];
    d3_pi[1] <= d3_pi[0];
    d3_pr[2] <= d3_pr[1];
    d3_pi[2] <= d3_pi[1];
  end
  assign d3_xro = d3_pr[2];
  assign d3_xio = d3_pi[2];

  int checks = 0;
  int errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: slot contents, latched inverse flag, bin select and
  // the queue of results still owed for the frame in flight.
  logic [3:0] m_re [4];
  logic [3:0] m_im [4];
  logic       m_c3, m_valid, m_ready;
  logic [1:0] m_c, m_n;
  res_t       exp_q [$];
  res_t       m_pop;
  int         cyc = 0;
  int         valid_at = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < 4; i++) begin
        m_re[i] = '0;
        m_im[i] = '0;
      end
      m_c3 = 1'b0;
      m_c  = 2'd0;
      m_n  = 2'd0;
      exp_q.delete();
    end else begin
      cyc++;
      m_ready = (exp_q.size() == 0);
      m_valid = !m_ready && (cyc >= valid_at);
      check("in_ready", in_ready, m_ready);
      check("busy", busy, !m_ready);
      check("out_valid", out_valid, m_valid);
      check("c2c1", {c2, c1}, m_c);
      check("c3", c3, m_c3);
      check("xr0", xr0, m_re[0]);
      check("xr1", xr1, m_re[1]);
      check("xr2", xr2, m_re[2]);
      check("xr3", xr3, m_re[3]);
      check("xi0", xi0, m_im[0]);
      check("xi1", xi1, m_im[1]);
      check("xi2", xi2, m_im[2]);
      check("xi3", xi3, m_im[3]);
      if (m_valid) begin
        check("out_re", out_re, exp_q[0].re);
        check("out_im", out_im, exp_q[0].im);
        check("out_k", out_k, exp_q[0].k);
        check("out_last", out_last, exp_q[0].last);
      end
      // Predict the handshakes at the coming edge.
      if (in_valid && m_ready) begin
        m_re[m_n] = in_re;
        m_im[m_n] = in_im;
        if (m_n == 2'd0) m_c3 = inv;
        if (m_n == 2'd3) begin
          for (int j = 0; j < 4; j++)
            exp_q.push_back('{k: 2'(j),
                              re: bf_re(m_re[0], m_re[1], m_re[2], m_re[3], 2'(j)),
                              im: bf_im(m_im[0], m_im[1], m_im[2], m_im[3], 2'(j), m_c3),
                              last: (j == 3)});
          m_c      = 2'd0;
          valid_at = cyc + 2 + LAT1;
        end
        m_n = m_n + 2'd1;
      end
      if (m_valid && out_ready) begin
        m_pop = exp_q.pop_front();
        if (m_pop.k != 2'd3) begin
          m_c      = m_pop.k + 2'd1;
          valid_at = cyc + 2 + LAT1;
        end
      end
    end
  end

  task automatic send(input logic [3:0] re, input logic [3:0] im, input logic iv, output int waited);
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    inv      = iv;
    waited   = 0;
    do begin
      @(negedge CLK);
      waited++;
    end while (!in_ready && waited < 300);
    check("in_accept", in_ready, 1);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_valid(output int waited);
    waited = 0;
    while (!out_valid && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    check("wait_out_valid", out_valid, 1);
  endtask

  task automatic drain();
    int w;
    in_valid = 1'b0;
    w = 0;
    do begin
      @(negedge CLK);
      w++;
    end while (!in_ready && w < 500);
    check("drain", in_ready, 1);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_c"}, {c3, c2, c1}, 0);
    check({tag, "_xr"}, {xr3, xr2, xr1, xr0}, 0);
    check({tag, "_xi"}, {xi3, xi2, xi1, xi0}, 0);
    check({tag, "_out_re"}, out_re, 0);
    check({tag, "_out_im"}, out_im, 0);
    check({tag, "_out_k"}, out_k, 0);
    check({tag, "_out_last"}, out_last, 0);
  endtask

  int w, n;
  bit done;

  initial begin
    in_valid = 1'b0; in_re = '0; in_im = '0; inv = 1'b0; out_ready = 1'b0;
    d3_in_valid = 1'b0; d3_in_re = '0; d3_in_im = '0; d3_inv = 1'b0; d3_out_ready = 1'b1;
    done = 1'b0;
    #2 RST = 1'b0;
    @(negedge CLK);
    check_reset_outputs("por");
    @(posedge CLK); #1 RST = 1'b1;

    // Reset values and reset in the middle of WAIT.
    send(4'd1, 4'd0, 1'b0, w);
    send(4'd2, 4'd0, 1'b0, w);
    send(4'd3, 4'd0, 1'b0, w);
    send(4'd4, 4'd0, 1'b0, w);
    in_valid = 1'b0;
    check("load_xr0", xr0, 1);
    check("load_xr1", xr1, 2);
    check("load_xr2", xr2, 3);
    check("load_xr3", xr3, 4);
    check("load_xi", {xi3, xi2, xi1, xi0}, 0);
    check("issue_busy", busy, 1);
    @(posedge CLK); #2;
    check("wait_no_valid", out_valid, 0);
    RST = 1'b0;
    #1 check_reset_outputs("async");
    @(negedge CLK);
    check_reset_outputs("reset_edge");
    @(posedge CLK); #1 RST = 1'b1;

    // Single frame, no stall: stub gives k+5 for all-zero samples.
    out_ready = 1'b1;
    repeat (4) send(4'd0, 4'd0, 1'b0, w);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!out_valid && n < 50);
    check("first_valid_latency", n, 3);
    for (int b = 0; b < 4; b++) begin
      wait_valid(n);
      if (b > 0) check("bin_spacing", n, 3);
      check("single_out_re", out_re, 5 + b);
      check("single_out_im", out_im, b);
      check("single_out_k", out_k, b);
      check("single_out_last", out_last, (b == 3) ? 1 : 0);
      @(posedge CLK); #1;
    end

    // Backpressure during k = 1.
    out_ready = 1'b0;
    send(4'd3, 4'd1, 1'b0, w);
    send(4'd6, 4'd2, 1'b0, w);
    send(4'd9, 4'd4, 1'b0, w);
    send(4'd12, 4'd8, 1'b0, w);
    in_valid = 1'b0;
    wait_valid(n);
    @(posedge CLK); #1 out_ready = 1'b1;
    @(posedge CLK); #1 out_ready = 1'b0;
    wait_valid(n);
    repeat (5) begin
      @(negedge CLK);
      check("stall_valid", out_valid, 1);
      check("stall_k", out_k, 1);
      check("stall_re", out_re, 12);
      check("stall_im", out_im, 3);
      check("stall_c2c1", {c2, c1}, 1);
      check("stall_in_ready", in_ready, 0);
    end
    @(posedge CLK); #1 out_ready = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("release_c2c1", {c2, c1}, 2);
    check("release_valid", out_valid, 0);
    drain();

    // inv latched with the first sample only.
    send(4'd1, 4'd1, 1'b1, w);
    check("inv_first", c3, 1);
    send(4'd2, 4'd2, 1'b0, w);
    send(4'd3, 4'd3, 1'b0, w);
    send(4'd4, 4'd4, 1'b0, w);
    check("inv_held", c3, 1);
    in_valid = 1'b0;
    wait_valid(n);
    check("inv_during_out", c3, 1);
    drain();
    send(4'd5, 4'd5, 1'b0, w);
    check("inv_next_frame", c3, 0);
    repeat (3) send(4'd6, 4'd7, 1'b1, w);
    check("inv_next_held", c3, 0);
    drain();

    // Back-to-back frames with in_valid held high.
    for (int f = 0; f < 8; f++) begin
      for (int s = 0; s < 4; s++) begin
        send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), w);
        if (f > 0 && s == 0) check("b2b_frame_gap", w, 13);
        if (s > 0) check("b2b_accept", w, 1);
      end
    end
    drain();

    // Random valid/ready traffic.
    fork
      begin
        for (int f = 0; f < 12; f++)
          for (int s = 0; s < 4; s++) begin
            idle($urandom_range(0, 2));
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), w);
          end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge CLK); #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // BFLY_LAT = 3 instance: latency and capture point.
    for (int s = 0; s < 4; s++) begin
      d3_in_valid = 1'b1;
      case (s)
        0:       begin d3_in_re = 4'd3; d3_in_im = 4'd5; d3_inv = 1'b1; end
        1:       begin d3_in_re = 4'd7; d3_in_im = 4'd1; d3_inv = 1'b0; end
        2:       begin d3_in_re = 4'd2; d3_in_im = 4'd2; d3_inv = 1'b0; end
        default: begin d3_in_re = 4'd9; d3_in_im = 4'd4; d3_inv = 1'b0; end
      endcase
      @(negedge CLK);
      check("d3_in_ready", d3_in_ready, 1);
      @(posedge CLK); #1;
    end
    d3_in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!d3_out_valid && n < 50);
    check("d3_first_latency", n, 5);
    check("d3_k0_re", d3_out_re, 8);
    check("d3_k0_im", d3_out_im, 13);
    check("d3_k0_k", d3_out_k, 0);
    @(posedge CLK); #1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!d3_out_valid && n < 50);
    check("d3_bin_spacing", n, 5);
    check("d3_k1_re", d3_out_re, 13);
    check("d3_k1_im", d3_out_im, 8);
    check("d3_k1_k", d3_out_k, 1);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!d3_in_ready && n < 100);
    check("d3_drain", d3_in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
